insn_parcel_buffer: RTL and testbench

Parametrised successor to the fixed 4-entry instruction buffer: a circular FIFO of 16-bit parcels (pc, fault, parcel) between fetch and decode. Fetch pushes an aligned line of FETCH_PARCELS parcels, with a start offset for misaligned entry points. Decode pops one whole instruction per cycle: a compressed (16-bit) instruction or a 32-bit instruction assembled from two parcels that may straddle fetch lines and the wrap point.

---
 rtl/insn_parcel_buffer_pkg.sv | 28 ++
 rtl/insn_parcel_buffer.sv | 142 ++++++++++++++
 tb/tb_insn_parcel_buffer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/insn_parcel_buffer_pkg.sv
// Shared types and helpers for the instruction parcel buffer between fetch and decode.
package insn_parcel_buffer_pkg;

  localparam int unsigned INSN_BUFFER_ENTRY_COUNT = 8;
  localparam int unsigned INSN_FETCH_PARCELS      = 2;
  localparam int unsigned INSN_PC_WIDTH           = 32;

  typedef logic [15:0] parcel_t;

  typedef logic [$clog2(INSN_BUFFER_ENTRY_COUNT)-1:0] insn_buffer_ptr_t;
  typedef logic [$clog2(INSN_BUFFER_ENTRY_COUNT):0]   insn_buffer_entry_count_t;

  typedef struct packed {
    logic [INSN_PC_WIDTH-1:0] pc;
    logic                     fault;
    parcel_t                  insn;
  } insn_buffer_entry_t;

  // Anything other than 2'b11 in the low bits marks a 16-bit instruction.
  function automatic logic is_compressed(parcel_t parcel);
    return parcel[1:0] != 2'b11;
  endfunction

  function automatic logic is_pow2(int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/insn_parcel_buffer.sv
// Circular FIFO of 16-bit parcels; fetch pushes whole lines, decode pops one
// compressed or 32-bit instruction per cycle straight from the head entries.
module insn_parcel_buffer
  import insn_parcel_buffer_pkg::*;
#(
  parameter int unsigned ENTRY_COUNT   = INSN_BUFFER_ENTRY_COUNT,
  parameter int unsigned FETCH_PARCELS = INSN_FETCH_PARCELS,
  parameter int unsigned PC_WIDTH      = INSN_PC_WIDTH
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic                        flush,
  input  logic                        writeValid,
  output logic                        writeReady,
  input  logic [PC_WIDTH-1:0]         writePc,
  input  logic [FETCH_PARCELS*16-1:0] writeData,
  input  logic                        writeFault,
  output logic                        readValid,
  input  logic                        readReady,
  output logic [PC_WIDTH-1:0]         readPc,
  output logic [31:0]                 readInsn,
  output logic                        readCompressed,
  output logic                        readFault
);

  localparam int unsigned PtrW = $clog2(ENTRY_COUNT);
  localparam int unsigned OffW = $clog2(FETCH_PARCELS);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   cnt_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic                fault;
    parcel_t             insn;
  } entry_t;

  if (!is_pow2(ENTRY_COUNT) || !is_pow2(FETCH_PARCELS) || (FETCH_PARCELS < 2) ||
      (ENTRY_COUNT < 2 * FETCH_PARCELS)) begin : g_bad_params
    $error("insn_parcel_buffer: invalid ENTRY_COUNT/FETCH_PARCELS");
  end

  entry_t mem_q [ENTRY_COUNT];
  ptr_t   head_q, head_d, tail_q, tail_d;
  cnt_t   count_q, count_d;

  logic [OffW-1:0]     start;
  logic [PC_WIDTH-1:0] line_base;
  logic                push, pop;
  cnt_t                push_n, pop_n;
  entry_t              head_entry;
  ptr_t                head_next;
  logic                unused_pc_lsb;

  assign unused_pc_lsb = writePc[0];
  assign start         = writePc[OffW:1];
  assign line_base     = {writePc[PC_WIDTH-1:OffW+1], {(OffW + 1){1'b0}}};
  assign push_n        = cnt_t'(FETCH_PARCELS) - cnt_t'(start);

  // Ready looks only at the registered count, so a same-cycle pop never
  // lets a line in that would not otherwise fit.
  assign writeReady = count_q <= cnt_t'(ENTRY_COUNT - FETCH_PARCELS);
  assign push       = writeValid && writeReady && !flush;
  assign pop        = readValid && readReady && !flush;

  assign head_entry = mem_q[head_q];
  assign head_next  = head_q + ptr_t'(1);

  always_comb begin
    readValid      = 1'b0;
    readPc         = '0;
    readInsn       = '0;
    readCompressed = 1'b0;
    readFault      = 1'b0;
    pop_n          = '0;
    if (count_q != '0) begin
      // A faulted head goes out alone so decode never waits on a parcel
      // that fetch will not deliver.
      if (head_entry.fault || is_compressed(head_entry.insn)) begin
        readValid = 1'b1;
        readInsn  = {16'h0000, head_entry.insn};
        readFault = head_entry.fault;
        pop_n     = cnt_t'(1);
      end else if (count_q >= cnt_t'(2)) begin
        readValid = 1'b1;
        readInsn  = {mem_q[head_next].insn, head_entry.insn};
        readFault = mem_q[head_next].fault;
        pop_n     = cnt_t'(2);
      end
      if (readValid) begin
        readPc         = head_entry.pc;
        readCompressed = is_compressed(head_entry.insn);
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + ptr_t'(push_n);
      if (pop)  head_d = head_q + ptr_t'(pop_n);
      count_d = count_q + (push ? push_n : cnt_t'(0)) - (pop ? pop_n : cnt_t'(0));
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Parcels below the start offset belong to the previous path and are skipped.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < FETCH_PARCELS; i++) begin
        if (i >= int'(start)) begin
          mem_q[tail_q + ptr_t'(i) - ptr_t'(start)] <= entry_t'{
            pc:    line_base + PC_WIDTH'(2 * i),
            fault: writeFault,
            insn:  writeData[16*i +: 16]
          };
        end
      end
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rstN)
    count_q <= cnt_t'(ENTRY_COUNT));

endmodule

// File: tb/tb_insn_parcel_buffer.sv
// Randomised and directed bench for insn_parcel_buffer with a parcel-queue model
// and an instruction scoreboard checked whenever decode side outputs are sampled.
module tb_insn_parcel_buffer;

  localparam int EC = 8;
  localparam int FP = 2;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          flush = 1'b0;
  logic          writeValid = 1'b0;
  logic [PW-1:0] writePc = '0;
  logic [FP*16-1:0] writeData = '0;
  logic          writeFault = 1'b0;
  logic          readReady = 1'b0;
  logic          writeReady, readValid, readCompressed, readFault;
  logic [PW-1:0] readPc;
  logic [31:0]   readInsn;

  always #5 clk = ~clk;

  insn_parcel_buffer #(
    .ENTRY_COUNT  (EC),
    .FETCH_PARCELS(FP),
    .PC_WIDTH     (PW)
  ) dut (
    .clk           (clk),
    .rstN          (rstN),
    .flush         (flush),
    .writeValid    (writeValid),
    .writeReady    (writeReady),
    .writePc       (writePc),
    .writeData     (writeData),
    .writeFault    (writeFault),
    .readValid     (readValid),
    .readReady     (readReady),
    .readPc        (readPc),
    .readInsn      (readInsn),
    .readCompressed(readCompressed),
    .readFault     (readFault)
  );

  typedef struct {
    logic [31:0] pc;
    logic [15:0] d;
    logic        f;
  } parcel_m_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        comp;
    logic        fault;
    int          n;
  } insn_m_t;

  parcel_m_t pend_q[$];
  insn_m_t   exp_q[$];
  int        model_count;
  int        tests;
  int        fails;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    pend_q.delete();
    exp_q.delete();
    model_count = 0;
  endtask

  // Whole instructions are formed from the parcel stream as soon as they are complete.
  task automatic model_push(input logic [31:0] pc, input logic [FP*16-1:0] data, input logic f);
    int          s    = int'((pc >> 1) & (FP - 1));
    logic [31:0] base = pc & ~32'(2 * FP - 1);
    insn_m_t     e;
    for (int i = s; i < FP; i++) begin
      parcel_m_t p;
      p.pc = base + 32'(2 * i);
      p.d  = data[16*i +: 16];
      p.f  = f;
      pend_q.push_back(p);
    end
    model_count += FP - s;
    while (pend_q.size() > 0) begin
      if (pend_q[0].f || pend_q[0].d[1:0] != 2'b11) begin
        e.pc = pend_q[0].pc;  e.insn = {16'h0000, pend_q[0].d};
        e.comp = pend_q[0].d[1:0] != 2'b11;  e.fault = pend_q[0].f;  e.n = 1;
        exp_q.push_back(e);
        void'(pend_q.pop_front());
      end else if (pend_q.size() >= 2) begin
        e.pc = pend_q[0].pc;  e.insn = {pend_q[1].d, pend_q[0].d};
        e.comp = 1'b0;  e.fault = pend_q[1].f;  e.n = 2;
        exp_q.push_back(e);
        void'(pend_q.pop_front());
        void'(pend_q.pop_front());
      end else begin
        break;
      end
    end
  endtask

  // Monitor: compare the presented outputs, then advance the model by this cycle's traffic.
  always @(negedge clk) begin
    bit exp_v;
    bit w_ok;
    if (rstN) begin
      exp_v = exp_q.size() > 0;
      w_ok  = model_count <= EC - FP;
      check("writeReady", 32'(writeReady), 32'(w_ok));
      check("readValid", 32'(readValid), 32'(exp_v));
      if (exp_v) begin
        check("readPc", readPc, exp_q[0].pc);
        check("readInsn", readInsn, exp_q[0].insn);
        check("readCompressed", 32'(readCompressed), 32'(exp_q[0].comp));
        check("readFault", 32'(readFault), 32'(exp_q[0].fault));
      end else begin
        check("idle readPc", readPc, 32'h0);
        check("idle readInsn", readInsn, 32'h0);
        check("idle readFlags", {30'h0, readCompressed, readFault}, 32'h0);
      end
      if (flush) begin
        model_clear();
      end else begin
        if (readValid && readReady && exp_v) begin
          model_count -= exp_q[0].n;
          void'(exp_q.pop_front());
        end
        if (writeValid && w_ok) model_push(writePc, writeData, writeFault);
      end
    end
  end

  task automatic cyc(input logic wv, input logic [31:0] pc, input logic [FP*16-1:0] data,
                     input logic f, input logic rr, input logic fl);
    @(posedge clk);
    #1;
    writeValid = wv;
    writePc    = pc;
    writeData  = data;
    writeFault = f;
    readReady  = rr;
    flush      = fl;
  endtask

  task automatic idle(input int n, input logic rr);
    repeat (n) cyc(1'b0, 32'h0, '0, 1'b0, rr, 1'b0);
  endtask

  task automatic rand_cyc();
    logic [31:0] pc;
    pc = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 3) == 0) ? 32'h2 : 32'h0);
    cyc($urandom_range(0, 3) != 0, pc, $urandom, $urandom_range(0, 15) == 0,
        $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " readValid"}, 32'(readValid), 32'h0);
    check({tag, " writeReady"}, 32'(writeReady), 32'h1);
    check({tag, " readPc"}, readPc, 32'h0);
    check({tag, " readInsn"}, readInsn, 32'h0);
    check({tag, " readFlags"}, {30'h0, readCompressed, readFault}, 32'h0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    model_clear();
    #12;
    check_reset_outputs("reset");
    rstN = 1'b1;

    // 32-bit nop, then two compressed parcels in one line.
    cyc(1'b1, 32'h8000_0000, 32'h0000_0013, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    cyc(1'b1, 32'h8000_0000, 32'h4501_4581, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Misaligned entry: a 32-bit instruction straddling two lines.
    cyc(1'b1, 32'h8000_0002, 32'h0513_0000, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b1);
    cyc(1'b1, 32'h8000_0004, 32'h4501_0000, 1'b0, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Fill to capacity; the fifth line must be refused.
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 32'h8000_0100 + 32'(4 * i), 32'h00a0_0093 + 32'(i << 7), 1'b0, 1'b0, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);
    idle(6, 1'b1);

    // Faulted line whose first parcel looks like the start of a 32-bit insn.
    cyc(1'b1, 32'h8000_0010, 32'h0000_0003, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);

    // Three lines in, then flush together with a write and a pop.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 32'h8000_0200 + 32'(4 * i), 32'h0001_0013, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h8000_0300, 32'h4501_4581, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);

    repeat (3000) rand_cyc();

    // Leave content behind, then reset between clock edges.
    for (int i = 0; i < 2; i++)
      cyc(1'b1, 32'h8000_0400 + 32'(4 * i), 32'h0513_0013, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    @(posedge clk);
    #3;
    rstN = 1'b0;
    #1;
    check_reset_outputs("async reset");
    model_clear();
    @(posedge clk);
    #3;
    rstN = 1'b1;
    repeat (500) rand_cyc();
    idle(10, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
